// File: rtl/lzc_stream_pkg.sv
// Shared types and helpers for the streaming leading-zero/one counter.
package lzc_stream_pkg;

  // Operand accumulation states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SKIP  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Count width wide enough to hold WIDTH*MAX_BEATS without wrap.
  function automatic int cnt_w(input int width, input int max_beats);
    return $clog2(width * max_beats) + 1;
  endfunction

endpackage

// File: rtl/lzc_core.sv
// Combinational single-beat leading-zero counter.
// Log-depth search: each level asks whether the upper half of the
// remaining window is empty and, if so, records a count bit and shifts
// the lower half up.
module lzc_core #(
  parameter int WIDTH = 64,
  localparam int ZW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] d,
  output logic [ZW-1:0]    z,
  output logic             v
);

  logic [WIDTH-1:0] rem;

  // Binary search for the first set bit, MSB side first.
  always_comb begin
    rem = d;
    z   = '0;
    for (int s = ZW - 1; s >= 0; s--) begin
      if ((rem >> (WIDTH - (1 << s))) == '0) begin
        z[s] = 1'b1;
        rem  = rem << (1 << s);
      end
    end
    v = |d;
  end

endmodule

// File: rtl/lzc_stream.sv
// Multi-beat leading-zero/one counter with valid/ready on both sides.
// Beats arrive MSB-first; one registered result per operand.
module lzc_stream
  import lzc_stream_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int MAX_BEATS = 4,
  localparam int CNT_W    = cnt_w(WIDTH, MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_all,
  output logic             out_err
);

  localparam int ZW   = $clog2(WIDTH);
  localparam int BC_W = $clog2(MAX_BEATS + 2);
  localparam logic [BC_W-1:0] BC_SAT = BC_W'(MAX_BEATS + 1);
  localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_BEATS);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [BC_W-1:0]  bc_q, bc_d, bc_base;
  logic             err_q, err_d, err_base;
  logic             found_d, found_base;
  logic             mode_q, mode_eff;
  logic             out_valid_q, out_all_q, out_err_q;
  logic [CNT_W-1:0] out_cnt_q;

  logic             accept, first;
  logic [WIDTH-1:0] beat_d;
  logic [ZW-1:0]    core_z;
  logic             core_v;

  // A new result can be taken whenever the output slot is free or draining.
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // Any beat taken while no operand is open starts a new one (DONE can only
  // accept while its result is retiring the same cycle).
  assign first    = (state_q == IDLE) || (state_q == DONE);
  assign mode_eff = first ? in_mode : mode_q;
  assign beat_d   = mode_eff ? ~in_data : in_data;

  lzc_core #(.WIDTH(WIDTH)) u_core (
    .d (beat_d),
    .z (core_z),
    .v (core_v)
  );

  // Next accumulator values for the beat currently offered.
  always_comb begin
    cnt_base   = first ? '0 : cnt_q;
    bc_base    = first ? '0 : bc_q;
    err_base   = first ? 1'b0 : err_q;
    found_base = first ? 1'b0 : (state_q == SKIP);
    bc_d       = (bc_base == BC_SAT) ? bc_base : bc_base + BC_W'(1);
    cnt_d      = cnt_base;
    err_d      = err_base;
    found_d    = found_base;
    if (bc_d > BC_MAX) begin
      err_d = 1'b1;
    end else if (!found_base) begin
      if (core_v) begin
        cnt_d   = cnt_base + CNT_W'(core_z);
        found_d = 1'b1;
      end else begin
        cnt_d = cnt_base + CNT_W'(WIDTH);
      end
    end
  end

  // Operand FSM, accumulator state and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bc_q        <= '0;
      err_q       <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_cnt_q   <= '0;
      out_all_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (accept) begin
      cnt_q <= cnt_d;
      bc_q  <= bc_d;
      err_q <= err_d;
      if (first) mode_q <= in_mode;
      if (in_last) begin
        state_q     <= DONE;
        out_valid_q <= 1'b1;
        out_cnt_q   <= cnt_d;
        out_all_q   <= !found_d;
        out_err_q   <= err_d;
      end else begin
        state_q     <= found_d ? SKIP : ACCUM;
        out_valid_q <= 1'b0;
      end
    end else if (out_valid_q && out_ready) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_cnt   = out_cnt_q;
  assign out_all   = out_all_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_lzc_stream.sv
// Self-checking bench for lzc_stream (WIDTH=64, MAX_BEATS=4).
module tb_lzc_stream;

  localparam int WIDTH = 64;
  localparam int MAXB  = 4;
  localparam int CNT_W = 9;

  typedef struct packed {
    logic [15:0] cnt;
    logic        all;
    logic        err;
  } res_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CNT_W-1:0] out_cnt;
  logic             out_all;
  logic             out_err;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  res_t got_q[$];
  res_t exp_q[$];

  lzc_stream #(.WIDTH(WIDTH), .MAX_BEATS(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt),
    .out_all   (out_all),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result handshake that will occur at the next rising edge.
  always @(negedge clk)
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1)
      got_q.push_back(res_t'({16'(out_cnt), out_all, out_err}));

  // Reference: scan the concatenated operand MSB-first bit by bit.
  function automatic res_t model(input logic [63:0] beats[$], input bit mode);
    res_t r;
    int   n;
    bit   found;
    int   c;
    found = 1'b0;
    c = 0;
    n = (beats.size() > MAXB) ? MAXB : beats.size();
    for (int b = 0; b < n; b++)
      for (int i = 63; i >= 0; i--)
        if (!found) begin
          if ((beats[b][i] ^ mode) == 1'b1) found = 1'b1;
          else c++;
        end
    r.cnt = 16'(c);
    r.all = !found;
    r.err = beats.size() > MAXB;
    return r;
  endfunction

  // Offer one beat and hold it until accepted (bounded).
  task automatic drive_beat(input logic [63:0] d, input bit last, input bit mode);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_mode  = mode;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      w++;
      if (w > 200) begin
        compared++;
        mismatched++;
        $display("FAIL beat_accept_timeout: in_ready=%b required 1", in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send an operand; flip toggles in_mode on later beats (must be ignored).
  task automatic send_op(input logic [63:0] beats[$], input bit mode, input bit flip,
                         input bit gaps);
    for (int b = 0; b < beats.size(); b++) begin
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      if (gaps) #1;
      drive_beat(beats[b], b == beats.size() - 1, (b == 0) ? mode : (mode ^ flip));
    end
  endtask

  // Wait (bounded) for n results, plus a few cycles to expose duplicates.
  task automatic wait_results(input int n);
    int w;
    w = 0;
    while (got_q.size() < n && w < 500) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    compared++;
    if ({out_valid, out_cnt, out_all, out_err} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%b cnt=%0d all=%b err=%b expected all 0",
               out_valid, out_cnt, out_all, out_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    res_t g;
    got_q.delete();
    drive_beat(64'h1, 1'b1, 1'b0);
    @(negedge clk);
    compared++;
    if ({out_valid, out_cnt, out_all, out_err} !== {1'b1, 9'd63, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL single_latency: got v=%b cnt=%0d all=%b err=%b expected v=1 cnt=63 all=0 err=0",
               out_valid, out_cnt, out_all, out_err);
    end
    wait_results(1);
    compared++;
    if (got_q.size() != 1) begin
      mismatched++;
      $display("FAIL single_count: got %0d results expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      compared++;
      if (g !== res_t'({16'd63, 1'b0, 1'b0})) begin
        mismatched++;
        $display("FAIL single_result: got cnt=%0d all=%b err=%b expected 63/0/0", g.cnt, g.all, g.err);
      end
    end
    got_q.delete();
  endtask

  task automatic test_multi;
    logic [63:0] b[$];
    res_t e, g;
    got_q.delete();
    exp_q.delete();
    b.push_back(64'h0); b.push_back(64'h0); b.push_back(64'h8000_0000_0000_0000);
    send_op(b, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(res_t'({16'd128, 1'b0, 1'b0}));
    b.delete();
    repeat (4) b.push_back(64'h0);
    send_op(b, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(res_t'({16'd256, 1'b1, 1'b0}));
    // Mode 1: second beat offers mode 0, which must be ignored.
    b.delete();
    b.push_back(64'hFFFF_FFFF_FFFF_FFF0); b.push_back(64'h0);
    send_op(b, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(res_t'({16'd60, 1'b0, 1'b0}));
    wait_results(exp_q.size());
    compared++;
    if (got_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL multi_count: got %0d results expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL multi_result: got cnt=%0d all=%b err=%b expected cnt=%0d all=%b err=%b",
                 g.cnt, g.all, g.err, e.cnt, e.all, e.err);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow;
    logic [63:0] b[$];
    res_t g;
    int c0;
    got_q.delete();
    b.push_back(64'h00FF_0000_0000_0000);
    repeat (4) b.push_back(64'h0);
    c0 = cyc;
    send_op(b, 1'b0, 1'b0, 1'b0);
    compared++;
    if (cyc - c0 != 5) begin
      mismatched++;
      $display("FAIL overflow_beats: took %0d cycles expected 5", cyc - c0);
    end
    wait_results(1);
    compared++;
    if (got_q.size() != 1) begin
      mismatched++;
      $display("FAIL overflow_count: got %0d results expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      compared++;
      if (g !== res_t'({16'd8, 1'b0, 1'b1})) begin
        mismatched++;
        $display("FAIL overflow_result: got cnt=%0d all=%b err=%b expected 8/0/1", g.cnt, g.all, g.err);
      end
    end
    got_q.delete();
  endtask

  task automatic test_backpressure;
    res_t g;
    got_q.delete();
    out_ready = 1'b0;
    drive_beat(64'h1 << 5, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 64'h1 << 40;
    in_last  = 1'b1;
    in_mode  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if ({out_valid, out_cnt, in_ready} !== {1'b1, 9'd58, 1'b0}) begin
        mismatched++;
        $display("FAIL hold_stable: got v=%b cnt=%0d in_ready=%b expected v=1 cnt=58 in_ready=0",
                 out_valid, out_cnt, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL release_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    compared++;
    if ({out_valid, out_cnt} !== {1'b1, 9'd23}) begin
      mismatched++;
      $display("FAIL back_to_back: got v=%b cnt=%0d expected v=1 cnt=23", out_valid, out_cnt);
    end
    @(posedge clk); #1;
    compared++;
    if (got_q.size() != 2) begin
      mismatched++;
      $display("FAIL bp_count: got %0d results expected 2", got_q.size());
    end else begin
      g = got_q.pop_front();
      compared++;
      if (g.cnt !== 16'd58) begin
        mismatched++;
        $display("FAIL bp_first: got cnt=%0d expected 58", g.cnt);
      end
      g = got_q.pop_front();
      compared++;
      if (g.cnt !== 16'd23) begin
        mismatched++;
        $display("FAIL bp_second: got cnt=%0d expected 23", g.cnt);
      end
    end
    got_q.delete();
  endtask

  task automatic test_walking;
    logic [63:0] one;
    res_t g;
    int   c0, k;
    got_q.delete();
    one = 64'h1;
    c0 = cyc;
    for (int j = 63; j >= 0; j--) drive_beat(one << j, 1'b1, 1'b0);
    compared++;
    if (cyc - c0 != 64) begin
      mismatched++;
      $display("FAIL walking_rate: took %0d cycles expected 64", cyc - c0);
    end
    wait_results(64);
    compared++;
    if (got_q.size() != 64) begin
      mismatched++;
      $display("FAIL walking_count: got %0d results expected 64", got_q.size());
    end
    k = 63;
    while (got_q.size() > 0 && k >= 0) begin
      g = got_q.pop_front();
      compared++;
      if (g !== res_t'({16'(63 - k), 1'b0, 1'b0})) begin
        mismatched++;
        $display("FAIL walking_k%0d: got cnt=%0d all=%b err=%b expected cnt=%0d all=0 err=0",
                 k, g.cnt, g.all, g.err, 63 - k);
      end
      k--;
    end
    got_q.delete();
  endtask

  task automatic test_rst_mid;
    res_t g;
    got_q.delete();
    drive_beat(64'h0, 1'b0, 1'b0);
    drive_beat(64'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({out_valid, out_cnt, out_all, out_err, in_ready} !== {1'b0, 9'd0, 1'b0, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL rst_mid_outputs: got v=%b cnt=%0d all=%b err=%b rdy=%b expected 0/0/0/0/1",
               out_valid, out_cnt, out_all, out_err, in_ready);
    end
    @(posedge clk); #1;
    drive_beat(64'h1, 1'b1, 1'b0);
    wait_results(1);
    compared++;
    if (got_q.size() != 1) begin
      mismatched++;
      $display("FAIL rst_mid_count: got %0d results expected 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      compared++;
      if (g !== res_t'({16'd63, 1'b0, 1'b0})) begin
        mismatched++;
        $display("FAIL rst_mid_fresh: got cnt=%0d all=%b err=%b expected 63/0/0", g.cnt, g.all, g.err);
      end
    end
    got_q.delete();
  endtask

  task automatic test_random;
    logic [63:0] b[$];
    logic [63:0] one;
    res_t e, g;
    bit   drv_done, m;
    int   len;
    got_q.delete();
    exp_q.delete();
    drv_done = 1'b0;
    one = 64'h1;
    fork
      begin
        for (int op = 0; op < 40; op++) begin
          b.delete();
          m   = 1'($urandom_range(0, 1));
          len = $urandom_range(1, 6);
          for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 3))
              0:       b.push_back(64'h0);
              1:       b.push_back(~64'h0);
              2:       b.push_back({$urandom, $urandom});
              default: b.push_back((one << $urandom_range(0, 63)) ^ {64{m}});
            endcase
          end
          exp_q.push_back(model(b, m));
          send_op(b, m, 1'($urandom_range(0, 1)), 1'b1);
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_results(exp_q.size());
    compared++;
    if (got_q.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL random_count: got %0d results expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL random_result: got cnt=%0d all=%b err=%b expected cnt=%0d all=%b err=%b",
                 g.cnt, g.all, g.err, e.cnt, e.all, e.err);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_overflow();
    test_backpressure();
    test_walking();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
